golden_nonce_checker: RTL

GOLDEN_NONCE_CHECKER -- requirements
Module: golden_nonce_checker

---
 rtl/golden_nonce_checker_pkg.sv | 18 +
 rtl/golden_nonce_checker_fifo.sv | 48 ++++
 rtl/golden_nonce_checker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/golden_nonce_checker_pkg.sv
// Shared miner definitions: checker FSM states, default hasher latency and digest word positions.
package golden_nonce_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_NONCE_OFFSET = 32'd2;

  // Digest word 7 must be zero for a golden hash; word 6 is the optional target compare.
  localparam int GN_WORD_HI  = 255;
  localparam int GN_WORD_LO  = 224;
  localparam int TGT_WORD_HI = 223;
  localparam int TGT_WORD_LO = 192;

endpackage

// File: rtl/golden_nonce_checker_fifo.sv
// gn_fifo: synchronous power-of-two FIFO holding golden nonces; a push is accepted
// while full whenever a pop happens in the same cycle.
module gn_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/golden_nonce_checker.sv
// Tracks the nonce of each returning hash, flags golden hashes and queues their nonces.
// Optional macro GN_TARGET_CMP_EN adds target_lo and a word-6 <= target_lo criterion.
module golden_nonce_checker
  import golden_nonce_checker_pkg::*;
#(
  parameter logic [31:0] NONCE_OFFSET = DEFAULT_NONCE_OFFSET,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_load,
  input  logic [31:0]  nonce_base,
  input  logic         hash_strobe,
  input  logic [255:0] hash_in,
`ifdef GN_TARGET_CMP_EN
  input  logic [31:0]  target_lo,
`endif
  output logic         gn_valid,
  input  logic         gn_ready,
  output logic [31:0]  gn_nonce,
  output logic [7:0]   drop_cnt,
  output logic         nonce_wrap,
  output logic         busy
);

  state_t      state;
  logic [31:0] nonce_cnt;
  logic [31:0] blank_cnt;
  logic        counting;
  logic        tgt_ok;
  logic        gold_hit;
  logic        gold_vld_p1;
  logic [31:0] gold_nonce_p1;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        drop;
  logic [31:0] head;

`ifdef GN_TARGET_CMP_EN
  assign tgt_ok = (hash_in[TGT_WORD_HI:TGT_WORD_LO] <= target_lo);
  logic unused_hash;
  assign unused_hash = ^hash_in[TGT_WORD_LO-1:0];
`else
  assign tgt_ok = 1'b1;
  logic unused_hash;
  assign unused_hash = ^hash_in[GN_WORD_LO-1:0];
`endif

  // A coincident work_load wins: the strobe belongs to the old work and is dropped.
  assign counting = (state != IDLE) && hash_strobe && !work_load;
  assign gold_hit = (state == RUN) && counting &&
                    (hash_in[GN_WORD_HI:GN_WORD_LO] == 32'h0) && tgt_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nonce_cnt  <= '0;
      blank_cnt  <= '0;
      nonce_wrap <= 1'b0;
      busy       <= 1'b0;
    end else begin
      nonce_wrap <= 1'b0;
      if (work_load) begin
        state     <= BLANK;
        nonce_cnt <= nonce_base;
        blank_cnt <= '0;
        busy      <= 1'b1;
      end else begin
        if (counting) begin
          nonce_cnt  <= nonce_cnt + 32'd1;
          nonce_wrap <= (nonce_cnt == 32'hFFFF_FFFF);
        end
        if (state == BLANK) begin
          if (blank_cnt >= NONCE_OFFSET) begin
            state <= RUN;
          end else if (hash_strobe) begin
            blank_cnt <= blank_cnt + 32'd1;
            if (blank_cnt + 32'd1 == NONCE_OFFSET) state <= RUN;
          end
        end
      end
    end
  end

  // Stage p1: registered golden decision and its nonce, pushed on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gold_vld_p1 <= 1'b0;
    else        gold_vld_p1 <= gold_hit;
  end

  always_ff @(posedge clk) begin
    if (gold_hit) gold_nonce_p1 <= nonce_cnt - NONCE_OFFSET;
  end

  assign gn_valid = !fifo_empty;
  assign gn_nonce = gn_valid ? head : 32'h0;
  assign pop      = gn_valid && gn_ready;
  assign drop     = gold_vld_p1 && fifo_full && !pop;

  gn_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gold_vld_p1),
    .push_data (gold_nonce_p1),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        drop_cnt <= 8'h00;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule
